// File: rtl/mem_wb_load.sv
// MEM/WB pipeline register with load-data extraction and sign/zero extension.
// Drives the register file write port directly from the registered WB entry.
module mem_wb_load #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int SW = 6
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic [SW-1:0] stall,
    input  logic          flush,
    input  logic [AW-1:0] mem_wd,
    input  logic          mem_wreg,
    input  logic [DW-1:0] mem_wdata,
    input  logic [2:0]    mem_ldop,
    input  logic [DW-1:0] dram_rdata,
    output logic [AW-1:0] wb_wd,
    output logic          wb_wreg,
    output logic [DW-1:0] wb_wdata,
    output logic          wb_ade
);

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LBU  = 3'b010;
    localparam logic [2:0] LD_LH   = 3'b011;
    localparam logic [2:0] LD_LHU  = 3'b100;
    localparam logic [2:0] LD_LW   = 3'b101;

    logic [AW-1:0] wd_q, wd_d;
    logic          wreg_q, wreg_d;
    logic [DW-1:0] data_q, data_d;
    logic [2:0]    ldop_q, ldop_d;
    logic [1:0]    off_q, off_d;
    logic          hold_vld_q, hold_vld_d;
    logic [DW-1:0] ld_hold_q, ld_hold_d;

    logic          is_load;
    logic [DW-1:0] word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    // Only the MEM and WB stall bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^stall[3:0];

    assign is_load = (ldop_q == LD_LB) || (ldop_q == LD_LBU) ||
                     (ldop_q == LD_LH) || (ldop_q == LD_LHU) ||
                     (ldop_q == LD_LW);

    // Next entry: flush beats stall; a held load latches its first-cycle RAM word.
    always_comb begin
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        data_d     = data_q;
        ldop_d     = ldop_q;
        off_d      = off_q;
        hold_vld_d = hold_vld_q;
        ld_hold_d  = ld_hold_q;
        if (flush || (stall[4] && !stall[5])) begin
            wd_d       = '0;
            wreg_d     = 1'b0;
            data_d     = '0;
            ldop_d     = LD_NONE;
            off_d      = 2'b00;
            hold_vld_d = 1'b0;
        end else if (stall[4] && stall[5]) begin
            if (is_load && !hold_vld_q) begin
                ld_hold_d  = dram_rdata;
                hold_vld_d = 1'b1;
            end
        end else begin
            wd_d       = mem_wd;
            wreg_d     = mem_wreg;
            data_d     = mem_wdata;
            ldop_d     = mem_ldop;
            off_d      = mem_wdata[1:0];
            hold_vld_d = 1'b0;
        end
    end

    // Entry registers; reset discards any held load data.
    always_ff @(posedge Clk or posedge Rst_n) begin
        if (Rst_n) begin
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            data_q     <= '0;
            ldop_q     <= LD_NONE;
            off_q      <= 2'b00;
            hold_vld_q <= 1'b0;
            ld_hold_q  <= '0;
        end else begin
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            data_q     <= data_d;
            ldop_q     <= ldop_d;
            off_q      <= off_d;
            hold_vld_q <= hold_vld_d;
            ld_hold_q  <= ld_hold_d;
        end
    end

    // Big-endian byte/half selection from the effective load word.
    always_comb begin
        word = hold_vld_q ? ld_hold_q : dram_rdata;
        unique case (off_q)
            2'd0:    byte_sel = word[DW-1:DW-8];
            2'd1:    byte_sel = word[DW-9:DW-16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        half_sel = off_q[1] ? word[15:0] : word[DW-1:DW-16];
    end

    // Extension, misalignment detection and write-port drive.
    always_comb begin
        wb_ade = 1'b0;
        unique case (ldop_q)
            LD_LB:   wb_wdata = {{(DW-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  wb_wdata = {{(DW-8){1'b0}}, byte_sel};
            LD_LH: begin
                wb_wdata = {{(DW-16){half_sel[15]}}, half_sel};
                wb_ade   = off_q[0];
            end
            LD_LHU: begin
                wb_wdata = {{(DW-16){1'b0}}, half_sel};
                wb_ade   = off_q[0];
            end
            LD_LW: begin
                wb_wdata = word;
                wb_ade   = (off_q != 2'b00);
            end
            default: wb_wdata = data_q;
        endcase
        wb_wd   = wd_q;
        wb_wreg = wreg_q & ~wb_ade;
    end

endmodule

// File: doc/mem_wb_load.md
Name: mem_wb_load

Overview:
- MEM/WB pipeline register for the five-stage core, placed directly upstream of the register file.
- Registers the MEM-stage write-back request and drives the register file write port (we/waddr/wdata).
- Performs load-data extraction and sign/zero extension on data-RAM read data. The data RAM reads synchronously, so the data arrives in the WB cycle.
- Handles pipeline stall, bubble and flush. Detects misaligned loads and suppresses their write-back.

Parameters:
- DW, 32, data/register width
- AW, 5, register address width (32 registers)
- SW, 6, stall vector width (bit 4 = MEM stage, bit 5 = WB stage)

Ports:
- Clk  in  1  clock, rising-edge
- Rst_n  in  1  asynchronous reset, active-high (1 = reset asserted, RstEnable)
- stall  in  SW  pipeline stall vector from control
- flush  in  1  exception flush; kills the entry being captured
- mem_wd  in  AW  destination register from MEM
- mem_wreg  in  1  write-enable from MEM
- mem_wdata  in  DW  ALU result; for loads, the effective byte address
- mem_ldop  in  3  load type: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw; 110/111 treated as none
- dram_rdata  in  DW  data-RAM read word; valid in the cycle after the load address was in MEM; big-endian (byte 0 = bits 31:24)
- wb_wd  out  AW  to regfile waddr
- wb_wreg  out  1  to regfile we
- wb_wdata  out  DW  to regfile wdata
- wb_ade  out  1  load address error, asserted for the cycle the faulting entry is in WB

Behaviour:
- State: wd_r, wreg_r, data_r, ldop_r, off_r (= mem_wdata[1:0]), hold_vld, ld_hold[DW].
- Reset (Rst_n=1, async): all state cleared.
  - Outputs: wb_wd=0, wb_wreg=0, wb_wdata=0, wb_ade=0.
  - A reset arriving mid-stall discards held data; no write occurs while reset is asserted.
- Capture on each rising edge, in priority order:
  - flush=1: load a bubble (wreg_r=0, wd_r=0, data_r=0, ldop_r=none, hold_vld=0).
  - stall[4]=1, stall[5]=0: bubble.
  - stall[4]=1, stall[5]=1: hold all entry fields.
  - stall[4]=0: capture the mem_* inputs and clear hold_vld.
  - stall[4]=0 with stall[5]=1 is illegal; capture anyway, no check required.
- Load-data hold:
  - When the entry is held and ldop_r!=none and hold_vld=0: ld_hold<=dram_rdata, hold_vld<=1.
  - Effective load word: ld_hold if hold_vld=1, else dram_rdata.
  - Result: the first-cycle RAM data is preserved through any stall length.
- Extraction (combinational from ldop_r, off_r, effective word):
  - lb/lbu: byte selected by off_r (0→31:24, 1→23:16, 2→15:8, 3→7:0); sign- or zero-extended to DW.
  - lh/lhu: off_r=0→31:16, off_r=2→15:0; sign- or zero-extended.
  - lw: full word.
  - none: wb_wdata=data_r.
- Misalignment:
  - wb_ade=1 when (lh|lhu) and off_r[0]=1, or lw and off_r!=0.
  - Otherwise wb_ade=0.
- Write enable: wb_wreg = wreg_r & ~wb_ade, so a faulting load never writes. wb_wd=wd_r unchanged.
- Latency: MEM → regfile write is one cycle; the write commits at the next edge inside the regfile.
- Stalled WB:
  - wb_wreg stays asserted while the entry is held.
  - The repeated write of an identical value is harmless and required for regfile forwarding.
- Register 0: no special handling; the regfile ignores waddr 0.

Test Plan:
- lb with mem_wdata=0x00001001, dram_rdata=0x11F23344, wreg=1, wd=5 → next cycle wb_wreg=1, wb_wd=5, wb_wdata=0xFFFFFFF2, wb_ade=0; lbu same → 0x000000F2.
- lh with off=2, dram_rdata=0xAABBCCDD → wb_wdata=0xFFFFCCDD; lhu → 0x0000CCDD; lw off=0 → 0xAABBCCDD.
- lw with mem_wdata=0x00000102 → wb_ade=1, wb_wreg=0 for exactly one cycle; lh off=1 → same.
- lbu off=3, then stall=6'b110000 for 3 cycles with dram_rdata changing 0x000000AB→0x12345678 after cycle 1 → wb_wdata stays 0x000000AB throughout; on release the next entry is captured.
- stall=6'b010000 → bubble: wb_wreg=0, wb_wdata=0. flush=1 together with stall[4]=0 and a valid load → bubble (flush wins).
- Reset asserted mid-hold, between clock edges → outputs go to 0 immediately; after release wb_wreg=0 until a new capture.
